// File: rtl/std_skid_buffer.sv
// Two-entry valid/ready skid buffer (register slice).
// Registers both the forward (valid/data) and backward (ready) paths while
// sustaining one word per cycle. out_load pulses for the cycle after the head
// register is written so it can drive a downstream register enable directly.
module std_skid_buffer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_load,
  output logic [1:0]       occupancy
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_head_d;
  logic [WIDTH-1:0] w_skid_d;
  logic             w_head_we;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_out_load;
  logic             w_in_fire;
  logic             w_out_fire;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // Next-state and storage update selection.
  always_comb begin
    w_state_d = r_state;
    w_head_d  = r_head;
    w_skid_d  = r_skid;
    w_head_we = 1'b0;
    case (r_state)
      StEmpty: begin
        if (w_in_fire) begin
          w_state_d = StBusy;
          w_head_d  = in_data;
          w_head_we = 1'b1;
        end
      end
      StBusy: begin
        if (w_in_fire && w_out_fire) begin
          w_head_d  = in_data;
          w_head_we = 1'b1;
        end else if (w_in_fire) begin
          // Consumer stalled: park the new word in the skid register.
          w_state_d = StFull;
          w_skid_d  = in_data;
        end else if (w_out_fire) begin
          w_state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so only the consumer can move things.
        if (w_out_fire) begin
          w_state_d = StBusy;
          w_head_d  = r_skid;
          w_head_we = 1'b1;
        end
      end
      default: begin
        w_state_d = StEmpty;
      end
    endcase
  end

  // State, storage and registered handshake outputs; reset overrides every event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StEmpty;
      r_head      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_load  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_head      <= w_head_d;
      r_skid      <= w_skid_d;
      r_in_ready  <= (w_state_d != StFull);
      r_out_valid <= (w_state_d != StEmpty);
      r_out_load  <= w_head_we;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_head;
  assign out_load  = r_out_load;
  assign occupancy = r_state;

endmodule

// File: doc/std_skid_buffer.md
Name: std_skid_buffer

Overview:
- Two-entry valid/ready skid buffer (register slice) for the STD register library.
- Sits directly upstream of enable-gated data registers (STD_DFFRE-style): converts a producer's valid/ready stream into a registered data word, with a single-cycle capture pulse usable as a downstream register enable.
- Breaks the combinational path on both data/valid (forward) and ready (backward) while sustaining full throughput.

Parameters:
WIDTH, 16, data word width in bits (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high; sampled on rising edge of clk
in_valid  input  1  producer asserts when in_data is valid
in_ready  output  1  buffer can accept a word this cycle (registered)
in_data  input  WIDTH  producer data
out_valid  output  1  out_data holds a valid word (registered)
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  WIDTH  head word (registered)
out_load  output  1  one-cycle pulse: out_data/out_valid were loaded with a new word on the previous edge; drives downstream register enable
occupancy  output  2  number of words held: 0, 1 or 2

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). No asynchronous reset path.
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: head register (drives out_data) and skid register; both WIDTH bits.
- States: EMPTY (occupancy 0), BUSY (1, head valid), FULL (2, head + skid valid).
- EMPTY: in_fire -> BUSY, head<=in_data. Otherwise hold.
- BUSY, in_fire & out_fire -> BUSY, head<=in_data.
- BUSY, in_fire & !out_fire -> FULL, skid<=in_data; head unchanged.
- BUSY, !in_fire & out_fire -> EMPTY.
- BUSY, neither -> hold.
- FULL: in_ready=0, so no in_fire. out_fire -> BUSY, head<=skid. Otherwise hold.
- out_valid = (state != EMPTY), registered.
- in_ready registered: next value = (next state != FULL).
- occupancy registered, equals state encoding.
- out_load asserted for exactly the cycle after any edge on which head was written (EMPTY->BUSY, BUSY->BUSY with in_fire, FULL->BUSY).
- Latency: in_data accepted at edge N appears on out_data after edge N (one cycle) when the buffer is EMPTY, or when BUSY with out_fire at N.
- Throughput: one word per cycle when out_ready is held high.
- Ordering: strict FIFO; no word is dropped or duplicated.
- Holding: out_data is stable while out_valid=1 and out_ready=0.
- Producer contract: in_valid/in_data are ignored when in_ready=0. Producer must hold them until in_fire (checked by bench, not the DUT).
- out_ready may toggle freely, including while out_valid=0; it has no effect in EMPTY.
- Reset: on any rising edge with rst=1, regardless of state:
  - state -> EMPTY
  - out_valid=0, out_load=0, occupancy=0, in_ready=0
  - head=0, skid=0 (so out_data=0)
  - any held words are discarded
- First edge with rst=0: in_ready->1. The first word may be accepted on the following edge.
- Reset mid-transfer: an in_fire/out_fire coinciding with rst=1 has no effect. Reset wins over all events.

Test Plan:
- Reset: rst=1 for 2 cycles from any state (incl. FULL) -> out_valid=0, occupancy=0, out_data=0, in_ready=0. in_ready=1 one edge after rst falls.
- Streaming: out_ready=1, send 0x0001..0x0010 on back-to-back cycles -> same words out in order, one cycle latency, in_ready never drops, out_load high every cycle from 2nd edge.
- Backpressure: out_ready=0, send 0xAAAA, 0xBBBB, 0xCCCC held -> occupancy 1 then 2, in_ready=0 after 2nd accept, 0xCCCC held. Release out_ready -> outputs 0xAAAA, 0xBBBB, 0xCCCC in order.
- Simultaneous in/out in BUSY: head=0x1234, in 0x5678 with out_ready=1 -> occupancy stays 1, out_data=0x5678 next cycle, out_load=1.
- Reset mid-operation: FULL with 0x1111/0x2222, assert rst during out_fire -> neither word ever appears; next accepted word 0x3333 is first output.
- Random: random in_valid/out_ready (50%) over 10k words, WIDTH=16 and WIDTH=1 -> scoreboard exact ordering, no loss/duplication, out_data stable under stall.
